// File: rtl/task_7_in.sv
// task_7_in: input stage of task 7.
// Captures one whole manager packet into a register array, then replays it to
// the task core over a valid/ready link with a last-byte marker. Bytes beyond
// DEPTH are dropped and flagged through a sticky overflow indication.
module task_7_in #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic                  i_tvalid,
    input  logic                  i_tlast,
    output logic                  o_tready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    input  logic                  i_core_ready,
    output logic                  o_input_last,
    output logic                  o_busy,
    output logic                  o_overflow,
    output logic [11:0]           o_packet_size_in_bytes
);

    // count must reach DEPTH itself; addresses only need 0..DEPTH-1
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  tready_s;
    logic                  data_valid_s;
    logic                  last_s;
    logic                  accept_s;
    logic                  xfer_s;
    logic                  mem_we_s;
    logic [AW-1:0]         mem_waddr_s;

    // Output decode from the registered state (combinational, no extra latency)
    always_comb begin
        tready_s     = 1'b0;
        data_valid_s = 1'b0;
        last_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                tready_s = ~i_rst;
            end
            S_RECV: begin
                tready_s = ~i_rst;
            end
            S_DRAIN: begin
                data_valid_s = 1'b1;
                last_s       = (CW'(rd_ptr_q) == (count_q - CW'(1)));
            end
            default: begin
                tready_s     = 1'b0;
                data_valid_s = 1'b0;
                last_s       = 1'b0;
            end
        endcase
    end

    assign accept_s = i_tvalid & tready_s;
    assign xfer_s   = data_valid_s & i_core_ready;

    // Next-state, counter, pointer and buffer-write decode
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = {AW{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = {AW{1'b0}};
                    count_d     = CW'(1);
                    state_d     = i_tlast ? S_DRAIN : S_RECV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RECV: begin
                if (accept_s) begin
                    if (count_q < DEPTH_C) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = count_q[AW-1:0];
                        count_d     = count_q + CW'(1);
                    end else begin
                        // buffer full: byte dropped, overflow stays set until idle
                        overflow_d = 1'b1;
                    end
                    if (i_tlast) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RECV;
                    end
                end else begin
                    state_d = S_RECV;
                end
            end
            S_DRAIN: begin
                if (xfer_s) begin
                    if (last_s) begin
                        state_d    = S_IDLE;
                        rd_ptr_d   = {AW{1'b0}};
                        count_d    = {CW{1'b0}};
                        overflow_d = 1'b0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d    = S_IDLE;
                count_d    = {CW{1'b0}};
                rd_ptr_d   = {AW{1'b0}};
                overflow_d = 1'b0;
            end
        endcase
    end

    // Control registers with synchronous active-high reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            count_q    <= {CW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Packet buffer write port; contents need no reset since count gates reads
    always_ff @(posedge i_clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= i_tdata;
        end
    end

    assign o_tready               = tready_s;
    assign o_data_valid           = data_valid_s;
    assign o_data                 = data_valid_s ? mem_q[rd_ptr_q] : {DATA_WIDTH{1'b0}};
    assign o_input_last           = last_s;
    assign o_busy                 = (state_q != S_IDLE);
    assign o_overflow             = overflow_q;
    assign o_packet_size_in_bytes = 12'(count_q);

endmodule

// File: tb/tb_task_7_in.sv
// tb_task_7_in: directed testbench for task_7_in (DATA_WIDTH 8, DEPTH 64).
module tb_task_7_in;

    logic        clk;
    logic        i_rst;
    logic [7:0]  i_tdata;
    logic        i_tvalid;
    logic        i_tlast;
    logic        o_tready;
    logic [7:0]  o_data;
    logic        o_data_valid;
    logic        i_core_ready;
    logic        o_input_last;
    logic        o_busy;
    logic        o_overflow;
    logic [11:0] o_packet_size_in_bytes;

    int checks;
    int failures;

    task_7_in #(.DATA_WIDTH(8), .DEPTH(64)) dut (
        .i_clk                  (clk),
        .i_rst                  (i_rst),
        .i_tdata                (i_tdata),
        .i_tvalid               (i_tvalid),
        .i_tlast                (i_tlast),
        .o_tready               (o_tready),
        .o_data                 (o_data),
        .o_data_valid           (o_data_valid),
        .i_core_ready           (i_core_ready),
        .o_input_last           (o_input_last),
        .o_busy                 (o_busy),
        .o_overflow             (o_overflow),
        .o_packet_size_in_bytes (o_packet_size_in_bytes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one beat through the edge that accepts it
    task automatic send_beat(input logic [7:0] d, input logic last);
        i_tdata  = d;
        i_tvalid = 1'b1;
        i_tlast  = last;
        tick();
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = 8'h00; i_core_ready = 1'b0;
        tick(); tick();
        checks++; if (o_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_data_valid); end
        checks++; if (o_input_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", o_input_last); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", o_overflow); end
        checks++; if (o_packet_size_in_bytes !== 12'd0) begin failures++; $display("FAIL reset_size got=%0d exp=0", o_packet_size_in_bytes); end
        checks++; if (o_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", o_tready); end
        i_rst = 1'b0;
        #1;
        checks++; if (o_tready !== 1'b1) begin failures++; $display("FAIL release_tready got=%b exp=1", o_tready); end
    endtask

    task automatic test_basic();
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        i_core_ready = 1'b1;
        send_beat(8'h11, 1'b0);
        checks++; if (o_packet_size_in_bytes !== 12'd1) begin failures++; $display("FAIL basic_size_live got=%0d exp=1", o_packet_size_in_bytes); end
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b1);
        checks++; if (o_packet_size_in_bytes !== 12'd3) begin failures++; $display("FAIL basic_size got=%0d exp=3", o_packet_size_in_bytes); end
        checks++; if (o_tready !== 1'b0) begin failures++; $display("FAIL basic_tready_drain got=%b exp=0", o_tready); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_data_valid !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d] got=%b exp=1", i, o_data_valid); end
            checks++; if (o_data !== exp[i]) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, o_data, exp[i]); end
            checks++; if (o_input_last !== (i == 2)) begin failures++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, o_input_last, (i == 2)); end
            tick();
        end
        checks++; if (o_data_valid !== 1'b0) begin failures++; $display("FAIL basic_end_valid got=%b exp=0", o_data_valid); end
        checks++; if (o_tready !== 1'b1) begin failures++; $display("FAIL basic_end_tready got=%b exp=1", o_tready); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL basic_end_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [3];
        int idx;
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        idx = 0;
        i_core_ready = 1'b0;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b1);
        for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
            i_core_ready = cyc[0];
            #1;
            checks++; if (o_data_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[c%0d] got=%b exp=1", cyc, o_data_valid); end
            checks++; if (o_data !== exp[idx]) begin failures++; $display("FAIL bp_data[c%0d] got=%h exp=%h", cyc, o_data, exp[idx]); end
            checks++; if (o_input_last !== (idx == 2)) begin failures++; $display("FAIL bp_last[c%0d] got=%b exp=%b", cyc, o_input_last, (idx == 2)); end
            if (i_core_ready) idx++;
            tick();
        end
        checks++; if (idx !== 3) begin failures++; $display("FAIL bp_timeout got=%0d exp=3", idx); end
        checks++; if (o_data_valid !== 1'b0) begin failures++; $display("FAIL bp_end_valid got=%b exp=0", o_data_valid); end
        checks++; if (o_tready !== 1'b1) begin failures++; $display("FAIL bp_end_tready got=%b exp=1", o_tready); end
    endtask

    task automatic test_overflow();
        i_core_ready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            send_beat(8'(i), (i == 69));
            checks++; if (o_overflow !== (i >= 64)) begin failures++; $display("FAIL ovf_flag[%0d] got=%b exp=%b", i, o_overflow, (i >= 64)); end
            checks++; if (o_packet_size_in_bytes !== ((i >= 63) ? 12'd64 : 12'(i + 1))) begin failures++; $display("FAIL ovf_size[%0d] got=%0d", i, o_packet_size_in_bytes); end
        end
        // manager keeps offering junk during drain; it must be ignored
        i_core_ready = 1'b1;
        i_tvalid = 1'b1; i_tdata = 8'hEE; i_tlast = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) i_tvalid = 1'b0;
            #1;
            checks++; if (o_data !== 8'(i) || o_data_valid !== 1'b1) begin failures++; $display("FAIL ovf_data[%0d] got=%h v=%b exp=%h", i, o_data, o_data_valid, 8'(i)); end
            checks++; if (o_input_last !== (i == 63)) begin failures++; $display("FAIL ovf_last[%0d] got=%b exp=%b", i, o_input_last, (i == 63)); end
            checks++; if (o_overflow !== 1'b1 || o_tready !== 1'b0) begin failures++; $display("FAIL ovf_drain[%0d] ovf=%b tready=%b exp=1/0", i, o_overflow, o_tready); end
            tick();
        end
        i_tvalid = 1'b0;
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", o_overflow); end
        checks++; if (o_busy !== 1'b0 || o_data_valid !== 1'b0) begin failures++; $display("FAIL ovf_idle busy=%b valid=%b exp=0/0", o_busy, o_data_valid); end
        checks++; if (o_packet_size_in_bytes !== 12'd0) begin failures++; $display("FAIL ovf_size_clear got=%0d exp=0", o_packet_size_in_bytes); end
    endtask

    task automatic test_single_beat();
        i_core_ready = 1'b0;
        send_beat(8'hA5, 1'b1);
        checks++; if (o_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", o_data); end
        checks++; if (o_data_valid !== 1'b1 || o_input_last !== 1'b1) begin failures++; $display("FAIL single_vl valid=%b last=%b exp=1/1", o_data_valid, o_input_last); end
        checks++; if (o_packet_size_in_bytes !== 12'd1) begin failures++; $display("FAIL single_size got=%0d exp=1", o_packet_size_in_bytes); end
        i_core_ready = 1'b1;
        tick();
        checks++; if (o_data_valid !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL single_end valid=%b busy=%b exp=0/0", o_data_valid, o_busy); end
    endtask

    task automatic test_reset_in_drain();
        i_core_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_beat(8'(i), (i == 5));
        i_core_ready = 1'b1;
        tick(); tick();
        checks++; if (o_data !== 8'h03) begin failures++; $display("FAIL rstd_pre got=%h exp=03", o_data); end
        i_rst = 1'b1; i_core_ready = 1'b0;
        tick();
        checks++; if (o_data_valid !== 1'b0 || o_busy !== 1'b0) begin failures++; $display("FAIL rstd_state valid=%b busy=%b exp=0/0", o_data_valid, o_busy); end
        checks++; if (o_packet_size_in_bytes !== 12'd0) begin failures++; $display("FAIL rstd_size got=%0d exp=0", o_packet_size_in_bytes); end
        i_rst = 1'b0;
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b1);
        checks++; if (o_data !== 8'h01 || o_input_last !== 1'b0) begin failures++; $display("FAIL rstd_b0 got=%h last=%b exp=01/0", o_data, o_input_last); end
        checks++; if (o_packet_size_in_bytes !== 12'd2) begin failures++; $display("FAIL rstd_size2 got=%0d exp=2", o_packet_size_in_bytes); end
        i_core_ready = 1'b1;
        tick();
        checks++; if (o_data !== 8'h02 || o_input_last !== 1'b1) begin failures++; $display("FAIL rstd_b1 got=%h last=%b exp=02/1", o_data, o_input_last); end
        tick();
        checks++; if (o_data_valid !== 1'b0 || o_tready !== 1'b1) begin failures++; $display("FAIL rstd_end valid=%b tready=%b exp=0/1", o_data_valid, o_tready); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_single_beat();
        test_reset_in_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
